// File: rtl/divider_unit_if.sv
// Control/data bundle for the 8-bit restoring divider: load/start controls and
// switch data in, quotient/remainder/divisor and status flags out.
interface divider_unit_if;
    logic       Load_A;
    logic       Load_B;
    logic       Execute;
    logic [7:0] Din;
    logic [7:0] Qval;
    logic [7:0] Rval;
    logic [7:0] Dval;
    logic       Busy;
    logic       Done;
    logic       Div_Zero;

    // Controller side: drives loads, start and switch data; observes results.
    modport master (
        output Load_A, Load_B, Execute, Din,
        input  Qval, Rval, Dval, Busy, Done, Div_Zero
    );

    // Divider side.
    modport slave (
        input  Load_A, Load_B, Execute, Din,
        output Qval, Rval, Dval, Busy, Done, Div_Zero
    );
endinterface

// File: rtl/divider_unit.sv
// 8-bit unsigned sequential restoring divider: one Execute press runs eight
// shift/subtract iterations and leaves quotient and remainder in Q and R.
module divider_unit (
    input  logic          Clk,
    input  logic          Reset,
    divider_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] q;
    logic [7:0] r;
    logic [7:0] d;
    logic [2:0] count;
    logic       done;
    logic       div_zero;

    logic [8:0] trial;
    logic [8:0] diff;
    logic       any_load;

    // Partial remainder shifted left with the next dividend bit, then a 9-bit
    // trial subtract; diff[8] is the borrow.
    always_comb begin
        trial    = {r, q[7]};
        diff     = trial - {1'b0, d};
        any_load = bus.Load_A | bus.Load_B;
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments,
    // so every register samples pre-edge values and update order never matters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            q        <= 8'd0;
            r        <= 8'd0;
            d        <= 8'd0;
            count    <= 3'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (any_load) begin
                        if (bus.Load_A) d <= bus.Din;
                        if (bus.Load_B) begin
                            q <= bus.Din;
                            r <= 8'd0;
                        end
                        done     <= 1'b0;
                        div_zero <= 1'b0;
                    end else if (state == IDLE && bus.Execute) begin
                        if (d == 8'd0) begin
                            // Divide by zero resolves in one cycle: saturated
                            // quotient, dividend preserved as the remainder.
                            q        <= 8'hFF;
                            r        <= q;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            r        <= 8'd0;
                            count    <= 3'd0;
                            done     <= 1'b0;
                            div_zero <= 1'b0;
                            state    <= RUN;
                        end
                    end

                    // A held button keeps us parked here, so one press is one run.
                    if (state == HOLD && !bus.Execute) state <= IDLE;
                end

                RUN: begin
                    if (!diff[8]) begin
                        r <= diff[7:0];
                        q <= {q[6:0], 1'b1};
                    end else begin
                        r <= trial[7:0];
                        q <= {q[6:0], 1'b0};
                    end
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
                        done  <= 1'b1;
                        state <= HOLD;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Qval     = q;
    assign bus.Rval     = r;
    assign bus.Dval     = d;
    assign bus.Busy     = (state == RUN);
    assign bus.Done     = done;
    assign bus.Div_Zero = div_zero;

endmodule

// File: tb/tb_divider_unit.sv
// Directed self-checking bench for divider_unit: hand-computed quotient,
// remainder, latency and flag expectations for each scenario.
module tb_divider_unit;

    logic Clk;
    logic Reset;
    divider_unit_if bus ();

    divider_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_b(input logic [7:0] v);
        bus.Din = v; bus.Load_B = 1'b1;
        tick();
        bus.Load_B = 1'b0;
    endtask

    task automatic load_a(input logic [7:0] v);
        bus.Din = v; bus.Load_A = 1'b1;
        tick();
        bus.Load_A = 1'b0;
    endtask

    // Hold Execute for 'hold' edges, release, then follow Busy until it drops
    // (bounded). Returns how many sampled cycles had Busy high.
    task automatic run_div(input int hold, output int busy_cnt);
        busy_cnt = 0;
        bus.Execute = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.Busy) busy_cnt++;
        end
        bus.Execute = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.Busy) break;
            tick();
            if (bus.Busy) busy_cnt++;
        end
        check("busy_bounded", {7'd0, bus.Busy}, 8'd0);
    endtask

    task automatic divide(input string tag, input logic [7:0] dividend, input logic [7:0] divisor,
                          input logic [7:0] exp_q, input logic [7:0] exp_r);
        int bc;
        load_b(dividend);
        load_a(divisor);
        check({tag, "_done_clr"}, {7'd0, bus.Done}, 8'd0);
        run_div(1, bc);
        check({tag, "_busy_cycles"}, 8'(bc), 8'd8);
        check({tag, "_q"}, bus.Qval, exp_q);
        check({tag, "_r"}, bus.Rval, exp_r);
        check({tag, "_done"}, {7'd0, bus.Done}, 8'd1);
        tick();
    endtask

    initial begin
        int bc;
        Reset = 1'b1;
        bus.Load_A = 1'b0; bus.Load_B = 1'b0; bus.Execute = 1'b0; bus.Din = 8'd0;
        tick(); tick();
        check("rst_q", bus.Qval, 8'd0);
        check("rst_r", bus.Rval, 8'd0);
        check("rst_d", bus.Dval, 8'd0);
        check("rst_busy", {7'd0, bus.Busy}, 8'd0);
        check("rst_done", {7'd0, bus.Done}, 8'd0);
        check("rst_dz", {7'd0, bus.Div_Zero}, 8'd0);
        Reset = 1'b0;
        tick();

        // 200 / 7 with exact latency: Busy after edges k..k+7, result after k+8.
        load_b(8'd200);
        load_a(8'd7);
        check("t1_qload", bus.Qval, 8'd200);
        check("t1_dload", bus.Dval, 8'd7);
        bus.Execute = 1'b1;
        tick();
        bus.Execute = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("t1_busy_k%0d", i), {7'd0, bus.Busy}, 8'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("t1_busy_k%0d", i), {7'd0, bus.Busy}, 8'd1);
        end
        check("t1_done_early", {7'd0, bus.Done}, 8'd0);
        tick();
        check("t1_busy_end", {7'd0, bus.Busy}, 8'd0);
        check("t1_q", bus.Qval, 8'd28);
        check("t1_r", bus.Rval, 8'd4);
        check("t1_done", {7'd0, bus.Done}, 8'd1);
        tick();

        // Boundary quotients.
        divide("t2a", 8'd255, 8'd1,   8'd255, 8'd0);
        divide("t2b", 8'd5,   8'd9,   8'd0,   8'd5);
        divide("t2c", 8'd255, 8'd255, 8'd1,   8'd0);

        // Divide by zero: one-cycle path, never Busy.
        load_b(8'h2A);
        load_a(8'd0);
        bus.Execute = 1'b1;
        tick();
        check("t3_q", bus.Qval, 8'hFF);
        check("t3_r", bus.Rval, 8'h2A);
        check("t3_dz", {7'd0, bus.Div_Zero}, 8'd1);
        check("t3_done", {7'd0, bus.Done}, 8'd1);
        check("t3_busy", {7'd0, bus.Busy}, 8'd0);
        tick();
        check("t3_busy_hold", {7'd0, bus.Busy}, 8'd0);
        bus.Execute = 1'b0;
        tick();

        // Held button gives one run; re-press divides the old quotient.
        load_b(8'd200);
        load_a(8'd7);
        check("t4_dz_clr", {7'd0, bus.Div_Zero}, 8'd0);
        run_div(30, bc);
        check("t4_busy_cycles", 8'(bc), 8'd8);
        check("t4_q", bus.Qval, 8'd28);
        check("t4_r", bus.Rval, 8'd4);
        tick();
        run_div(1, bc);
        check("t4b_busy_cycles", 8'(bc), 8'd8);
        check("t4b_q", bus.Qval, 8'd4);
        check("t4b_r", bus.Rval, 8'd0);
        tick();

        // Reset on the 4th RUN cycle aborts the division.
        load_b(8'd100);
        load_a(8'd3);
        bus.Execute = 1'b1;
        tick();
        bus.Execute = 1'b0;
        tick(); tick(); tick();
        check("t5_busy_pre", {7'd0, bus.Busy}, 8'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t5_q", bus.Qval, 8'd0);
        check("t5_r", bus.Rval, 8'd0);
        check("t5_d", bus.Dval, 8'd0);
        check("t5_busy", {7'd0, bus.Busy}, 8'd0);
        check("t5_done", {7'd0, bus.Done}, 8'd0);
        bus.Execute = 1'b1;
        tick();
        bus.Execute = 1'b0;
        check("t5_dz", {7'd0, bus.Div_Zero}, 8'd1);
        check("t5_dz_q", bus.Qval, 8'hFF);
        check("t5_dz_r", bus.Rval, 8'd0);
        check("t5_dz_busy", {7'd0, bus.Busy}, 8'd0);
        tick();

        // Loads during RUN are ignored.
        load_b(8'd200);
        load_a(8'd7);
        bus.Execute = 1'b1;
        tick();
        bus.Execute = 1'b0;
        tick();
        bus.Din = 8'd3; bus.Load_A = 1'b1; bus.Load_B = 1'b1;
        tick(); tick();
        bus.Load_A = 1'b0; bus.Load_B = 1'b0;
        run_div(0, bc);
        check("t6_q", bus.Qval, 8'd28);
        check("t6_r", bus.Rval, 8'd4);
        check("t6_d", bus.Dval, 8'd7);
        tick(); tick();

        // Load_B with Execute in IDLE: load wins, no run.
        bus.Din = 8'd50; bus.Load_B = 1'b1; bus.Execute = 1'b1;
        tick();
        bus.Load_B = 1'b0; bus.Execute = 1'b0;
        check("t6b_busy", {7'd0, bus.Busy}, 8'd0);
        check("t6b_q", bus.Qval, 8'd50);
        check("t6b_r", bus.Rval, 8'd0);
        check("t6b_done", {7'd0, bus.Done}, 8'd0);
        tick();
        check("t6b_busy_next", {7'd0, bus.Busy}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
